// File: rtl/axi_mm_ram_pkg.sv
// Shared AXI encodings and FSM state types for the AXI memory-mapped RAM responder.
package axi_mm_ram_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_DATA,
    WR_RESP
  } wr_state_e;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_FETCH,
    RD_DATA
  } rd_state_e;

endpackage

// File: rtl/axi_mm_ram_array.sv
// Simple dual-port RAM: byte-enabled write port, registered read-first read port.
module axi_mm_ram_array #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_BITS  = 10
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [ADDR_BITS-1:0]    waddr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic [ADDR_BITS-1:0]    raddr,
  output logic [DATA_WIDTH-1:0]   rdata
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  // NOTE: the storage array has no reset; clearing it would turn the RAM into a register file.
  logic [DATA_WIDTH-1:0] mem [2**ADDR_BITS];

  // NOTE: non-blocking assignments make the read sample the pre-write contents (read-first).
  always_ff @(posedge clk) begin
    for (int i = 0; i < STRB_WIDTH; i++) begin
      if (we && wstrb[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/axi_mm_ram_slave.sv
// AXI4 burst responder backed by a byte-enabled RAM; one outstanding burst per direction.
module axi_mm_ram_slave
  import axi_mm_ram_pkg::*;
#(
  parameter int ID_WIDTH       = 1,
  parameter int ADDR_WIDTH     = 64,
  parameter int DATA_WIDTH     = 128,
  parameter int MEM_WORDS_LOG2 = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_axi_AWVALID,
  output logic                    s_axi_AWREADY,
  input  logic [ADDR_WIDTH-1:0]   s_axi_AWADDR,
  input  logic [ID_WIDTH-1:0]     s_axi_AWID,
  input  logic [7:0]              s_axi_AWLEN,
  input  logic [2:0]              s_axi_AWSIZE,
  input  logic [1:0]              s_axi_AWBURST,
  input  logic                    s_axi_WVALID,
  output logic                    s_axi_WREADY,
  input  logic [DATA_WIDTH-1:0]   s_axi_WDATA,
  input  logic [DATA_WIDTH/8-1:0] s_axi_WSTRB,
  input  logic                    s_axi_WLAST,
  output logic                    s_axi_BVALID,
  input  logic                    s_axi_BREADY,
  output logic [1:0]              s_axi_BRESP,
  output logic [ID_WIDTH-1:0]     s_axi_BID,
  input  logic                    s_axi_ARVALID,
  output logic                    s_axi_ARREADY,
  input  logic [ADDR_WIDTH-1:0]   s_axi_ARADDR,
  input  logic [ID_WIDTH-1:0]     s_axi_ARID,
  input  logic [7:0]              s_axi_ARLEN,
  input  logic [2:0]              s_axi_ARSIZE,
  input  logic [1:0]              s_axi_ARBURST,
  output logic                    s_axi_RVALID,
  input  logic                    s_axi_RREADY,
  output logic [DATA_WIDTH-1:0]   s_axi_RDATA,
  output logic                    s_axi_RLAST,
  output logic [ID_WIDTH-1:0]     s_axi_RID,
  output logic [1:0]              s_axi_RRESP
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int B          = $clog2(STRB_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] BEAT_BYTES = ADDR_WIDTH'(STRB_WIDTH);

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
    return (addr >> (B + MEM_WORDS_LOG2)) == '0;
  endfunction

  function automatic logic [MEM_WORDS_LOG2-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
    return addr[B +: MEM_WORDS_LOG2];
  endfunction

  function automatic logic burst_legal(input logic [1:0] burst, input logic [2:0] size);
    return ((burst == BURST_INCR) || (burst == BURST_FIXED)) && (size == 3'(B));
  endfunction

  // ---------------- write channel ----------------
  wr_state_e             wr_state, wr_state_nxt;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [ID_WIDTH-1:0]   aw_id;
  logic [7:0]            aw_len, wr_cnt;
  logic                  aw_fixed, aw_legal, wr_err;
  logic                  wr_last_beat, ram_we;

  assign wr_last_beat = (wr_cnt == aw_len);
  assign ram_we       = s_axi_WREADY && s_axi_WVALID && aw_legal && in_range(aw_addr);

  always_ff @(posedge clk) begin
    if (rst) wr_state <= WR_IDLE;
    else     wr_state <= wr_state_nxt;
  end

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    wr_state_nxt  = wr_state;
    s_axi_AWREADY = 1'b0;
    s_axi_WREADY  = 1'b0;
    s_axi_BVALID  = 1'b0;
    s_axi_BRESP   = RESP_OKAY;
    s_axi_BID     = '0;
    if (!rst) begin
      unique case (wr_state)
        WR_IDLE: begin
          s_axi_AWREADY = 1'b1;
          if (s_axi_AWVALID) wr_state_nxt = WR_DATA;
        end
        WR_DATA: begin
          s_axi_WREADY = 1'b1;
          if (s_axi_WVALID && wr_last_beat) wr_state_nxt = WR_RESP;
        end
        WR_RESP: begin
          s_axi_BVALID = 1'b1;
          s_axi_BRESP  = wr_err ? RESP_SLVERR : RESP_OKAY;
          s_axi_BID    = aw_id;
          if (s_axi_BREADY) wr_state_nxt = WR_IDLE;
        end
        default: wr_state_nxt = WR_IDLE;
      endcase
    end
  end

  // Burst length comes from AWLEN alone; a misplaced WLAST only poisons the response.
  always_ff @(posedge clk) begin
    if (rst) begin
      aw_addr  <= '0;
      aw_id    <= '0;
      aw_len   <= '0;
      wr_cnt   <= '0;
      aw_fixed <= 1'b0;
      aw_legal <= 1'b0;
      wr_err   <= 1'b0;
    end else begin
      if (s_axi_AWREADY && s_axi_AWVALID) begin
        aw_addr  <= s_axi_AWADDR;
        aw_id    <= s_axi_AWID;
        aw_len   <= s_axi_AWLEN;
        aw_fixed <= (s_axi_AWBURST == BURST_FIXED);
        aw_legal <= burst_legal(s_axi_AWBURST, s_axi_AWSIZE);
        wr_err   <= !burst_legal(s_axi_AWBURST, s_axi_AWSIZE);
        wr_cnt   <= '0;
      end
      if (s_axi_WREADY && s_axi_WVALID) begin
        if (!in_range(aw_addr) || (s_axi_WLAST != wr_last_beat)) wr_err <= 1'b1;
        if (!aw_fixed) aw_addr <= aw_addr + BEAT_BYTES;
        wr_cnt <= wr_cnt + 8'd1;
      end
    end
  end

  // ---------------- read channel ----------------
  rd_state_e                 rd_state, rd_state_nxt;
  logic [ADDR_WIDTH-1:0]     ar_addr, ar_next;
  logic [ID_WIDTH-1:0]       ar_id;
  logic [7:0]                ar_len, rd_cnt;
  logic                      ar_fixed, ar_legal;
  logic                      rd_last_beat, rd_beat_ok;
  logic [MEM_WORDS_LOG2-1:0] ram_raddr;
  logic [DATA_WIDTH-1:0]     ram_rdata;

  assign ar_next      = ar_fixed ? ar_addr : ar_addr + BEAT_BYTES;
  assign rd_last_beat = (rd_cnt == ar_len);
  assign rd_beat_ok   = ar_legal && in_range(ar_addr);

  always_ff @(posedge clk) begin
    if (rst) rd_state <= RD_IDLE;
    else     rd_state <= rd_state_nxt;
  end

  // Prefetching the next beat on a handshake keeps one beat per cycle; otherwise
  // re-reading the current word holds RDATA across a stall.
  always_comb begin
    rd_state_nxt  = rd_state;
    ram_raddr     = word_idx(ar_addr);
    s_axi_ARREADY = 1'b0;
    s_axi_RVALID  = 1'b0;
    s_axi_RLAST   = 1'b0;
    s_axi_RID     = '0;
    s_axi_RRESP   = RESP_OKAY;
    s_axi_RDATA   = '0;
    if (!rst) begin
      unique case (rd_state)
        RD_IDLE: begin
          s_axi_ARREADY = 1'b1;
          if (s_axi_ARVALID) rd_state_nxt = RD_FETCH;
        end
        RD_FETCH: rd_state_nxt = RD_DATA;
        RD_DATA: begin
          s_axi_RVALID = 1'b1;
          s_axi_RID    = ar_id;
          s_axi_RLAST  = rd_last_beat;
          s_axi_RRESP  = rd_beat_ok ? RESP_OKAY : RESP_SLVERR;
          s_axi_RDATA  = rd_beat_ok ? ram_rdata : '0;
          if (s_axi_RREADY) begin
            ram_raddr = word_idx(ar_next);
            if (rd_last_beat) rd_state_nxt = RD_IDLE;
          end
        end
        default: rd_state_nxt = RD_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ar_addr  <= '0;
      ar_id    <= '0;
      ar_len   <= '0;
      rd_cnt   <= '0;
      ar_fixed <= 1'b0;
      ar_legal <= 1'b0;
    end else begin
      if (s_axi_ARREADY && s_axi_ARVALID) begin
        ar_addr  <= s_axi_ARADDR;
        ar_id    <= s_axi_ARID;
        ar_len   <= s_axi_ARLEN;
        ar_fixed <= (s_axi_ARBURST == BURST_FIXED);
        ar_legal <= burst_legal(s_axi_ARBURST, s_axi_ARSIZE);
        rd_cnt   <= '0;
      end
      if (s_axi_RVALID && s_axi_RREADY) begin
        ar_addr <= ar_next;
        rd_cnt  <= rd_cnt + 8'd1;
      end
    end
  end

  axi_mm_ram_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_BITS  (MEM_WORDS_LOG2)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (word_idx(aw_addr)),
    .wdata (s_axi_WDATA),
    .wstrb (s_axi_WSTRB),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_axi_mm_ram_slave.sv
// Directed self-checking bench for axi_mm_ram_slave with hand-computed expectations.
module tb_axi_mm_ram_slave;
  import axi_mm_ram_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         s_axi_AWVALID, s_axi_AWREADY;
  logic [63:0]  s_axi_AWADDR;
  logic [0:0]   s_axi_AWID;
  logic [7:0]   s_axi_AWLEN;
  logic [2:0]   s_axi_AWSIZE;
  logic [1:0]   s_axi_AWBURST;
  logic         s_axi_WVALID, s_axi_WREADY;
  logic [127:0] s_axi_WDATA;
  logic [15:0]  s_axi_WSTRB;
  logic         s_axi_WLAST;
  logic         s_axi_BVALID, s_axi_BREADY;
  logic [1:0]   s_axi_BRESP;
  logic [0:0]   s_axi_BID;
  logic         s_axi_ARVALID, s_axi_ARREADY;
  logic [63:0]  s_axi_ARADDR;
  logic [0:0]   s_axi_ARID;
  logic [7:0]   s_axi_ARLEN;
  logic [2:0]   s_axi_ARSIZE;
  logic [1:0]   s_axi_ARBURST;
  logic         s_axi_RVALID, s_axi_RREADY;
  logic [127:0] s_axi_RDATA;
  logic         s_axi_RLAST;
  logic [0:0]   s_axi_RID;
  logic [1:0]   s_axi_RRESP;

  int checks = 0;
  int errors = 0;

  // Write stimulus and captured read/write results shared by the protocol tasks.
  logic [127:0] wr_data [256];
  logic [15:0]  wr_strb [256];
  int           wlast_at;
  int           wbeats;
  logic [1:0]   got_bresp;
  logic [0:0]   got_bid;
  logic [127:0] rd_data [256];
  logic [1:0]   rd_resp [256];
  logic         rd_last [256];
  logic [0:0]   rd_id;
  int           rd_beats;
  int           rd_lat;

  always #5 clk = ~clk;

  axi_mm_ram_slave #(
    .ID_WIDTH(1), .ADDR_WIDTH(64), .DATA_WIDTH(128), .MEM_WORDS_LOG2(10)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axi_AWVALID(s_axi_AWVALID), .s_axi_AWREADY(s_axi_AWREADY), .s_axi_AWADDR(s_axi_AWADDR),
    .s_axi_AWID(s_axi_AWID), .s_axi_AWLEN(s_axi_AWLEN), .s_axi_AWSIZE(s_axi_AWSIZE),
    .s_axi_AWBURST(s_axi_AWBURST), .s_axi_WVALID(s_axi_WVALID), .s_axi_WREADY(s_axi_WREADY),
    .s_axi_WDATA(s_axi_WDATA), .s_axi_WSTRB(s_axi_WSTRB), .s_axi_WLAST(s_axi_WLAST),
    .s_axi_BVALID(s_axi_BVALID), .s_axi_BREADY(s_axi_BREADY), .s_axi_BRESP(s_axi_BRESP),
    .s_axi_BID(s_axi_BID), .s_axi_ARVALID(s_axi_ARVALID), .s_axi_ARREADY(s_axi_ARREADY),
    .s_axi_ARADDR(s_axi_ARADDR), .s_axi_ARID(s_axi_ARID), .s_axi_ARLEN(s_axi_ARLEN),
    .s_axi_ARSIZE(s_axi_ARSIZE), .s_axi_ARBURST(s_axi_ARBURST), .s_axi_RVALID(s_axi_RVALID),
    .s_axi_RREADY(s_axi_RREADY), .s_axi_RDATA(s_axi_RDATA), .s_axi_RLAST(s_axi_RLAST),
    .s_axi_RID(s_axi_RID), .s_axi_RRESP(s_axi_RRESP)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: handshake not seen within bound", name);
  endtask

  task automatic axi_write(input logic [63:0] addr, input logic [0:0] id, input int len,
                           input logic [1:0] burst, input logic [2:0] size);
    int n;
    s_axi_AWVALID = 1'b1; s_axi_AWADDR = addr; s_axi_AWID = id;
    s_axi_AWLEN = 8'(len); s_axi_AWSIZE = size; s_axi_AWBURST = burst;
    n = 0;
    while (!s_axi_AWREADY && n < 100) begin tick; n++; end
    if (!s_axi_AWREADY) timeout("aw_ready");
    tick;
    s_axi_AWVALID = 1'b0;
    wbeats = 0;
    for (int i = 0; i <= len; i++) begin
      s_axi_WVALID = 1'b1; s_axi_WDATA = wr_data[i]; s_axi_WSTRB = wr_strb[i];
      s_axi_WLAST = (wlast_at < 0) ? (i == len) : (i == wlast_at);
      n = 0;
      while (!s_axi_WREADY && n < 100) begin tick; n++; end
      if (s_axi_WREADY) wbeats++;
      else timeout("w_ready");
      tick;
    end
    s_axi_WVALID = 1'b0; s_axi_WLAST = 1'b0;
    s_axi_BREADY = 1'b1;
    n = 0;
    while (!s_axi_BVALID && n < 100) begin tick; n++; end
    if (!s_axi_BVALID) timeout("b_valid");
    got_bresp = s_axi_BRESP; got_bid = s_axi_BID;
    tick;
    s_axi_BREADY = 1'b0;
    wlast_at = -1;
  endtask

  task automatic axi_read(input logic [63:0] addr, input logic [0:0] id, input int len,
                          input logic [1:0] burst, input logic [2:0] size, input bit stall);
    int n, cyc;
    bit prev_hold;
    logic [127:0] prev_data;
    s_axi_ARVALID = 1'b1; s_axi_ARADDR = addr; s_axi_ARID = id;
    s_axi_ARLEN = 8'(len); s_axi_ARSIZE = size; s_axi_ARBURST = burst;
    n = 0;
    while (!s_axi_ARREADY && n < 100) begin tick; n++; end
    if (!s_axi_ARREADY) timeout("ar_ready");
    tick;
    s_axi_ARVALID = 1'b0;
    rd_lat = 1;
    while (!s_axi_RVALID && rd_lat < 100) begin tick; rd_lat++; end
    rd_beats = 0; cyc = 0; prev_hold = 1'b0; prev_data = '0;
    while (rd_beats <= len && cyc < 2000) begin
      s_axi_RREADY = stall ? (cyc % 3 != 1) : 1'b1;
      if (prev_hold) begin
        checks++;
        if (s_axi_RDATA !== prev_data) begin
          errors++;
          $display("FAIL rdata_hold beat %0d: got %h want %h", rd_beats, s_axi_RDATA, prev_data);
        end
      end
      if (s_axi_RVALID && s_axi_RREADY) begin
        rd_data[rd_beats] = s_axi_RDATA; rd_resp[rd_beats] = s_axi_RRESP;
        rd_last[rd_beats] = s_axi_RLAST; rd_id = s_axi_RID;
        rd_beats++;
        prev_hold = 1'b0;
      end else begin
        prev_hold = s_axi_RVALID;
        prev_data = s_axi_RDATA;
      end
      tick;
      cyc++;
    end
    s_axi_RREADY = 1'b0;
    if (rd_beats <= len) timeout("r_beats");
  endtask

  // Compares a captured read burst against expected words and a single response code.
  task automatic check_read(input string name, input int len, input logic [127:0] exp [256],
                            input logic [1:0] exp_resp);
    for (int i = 0; i <= len; i++) begin
      checks++;
      if (rd_data[i] !== exp[i] || rd_resp[i] !== exp_resp || rd_last[i] !== (i == len)) begin
        errors++;
        $display("FAIL %s beat %0d: got data %h resp %0d last %b want data %h resp %0d last %b",
                 name, i, rd_data[i], rd_resp[i], rd_last[i], exp[i], exp_resp, (i == len));
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick; tick; tick;
    checks++;
    if ({s_axi_AWREADY, s_axi_WREADY, s_axi_BVALID, s_axi_ARREADY, s_axi_RVALID, s_axi_RLAST} !== 6'b0 ||
        s_axi_BRESP !== 2'b0 || s_axi_RRESP !== 2'b0 || s_axi_RDATA !== '0 ||
        s_axi_BID !== 1'b0 || s_axi_RID !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got ready/valid %b want 000000", {s_axi_AWREADY, s_axi_WREADY,
               s_axi_BVALID, s_axi_ARREADY, s_axi_RVALID, s_axi_RLAST});
    end
    rst = 1'b0;
    #1;
    checks++;
    if (s_axi_AWREADY !== 1'b1 || s_axi_ARREADY !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: got awready %b arready %b want 1 1", s_axi_AWREADY, s_axi_ARREADY);
    end
  endtask

  task automatic test_incr;
    logic [127:0] exp [256];
    for (int i = 0; i < 4; i++) begin wr_data[i] = 128'(i); wr_strb[i] = 16'hFFFF; exp[i] = 128'(i); end
    axi_write(64'h100, 1'b1, 3, BURST_INCR, 3'd4);
    checks++;
    if (got_bresp !== RESP_OKAY || got_bid !== 1'b1) begin
      errors++;
      $display("FAIL incr_bresp: got resp %0d id %0d want 0 1", got_bresp, got_bid);
    end
    axi_read(64'h100, 1'b1, 3, BURST_INCR, 3'd4, 1'b0);
    checks++;
    if (rd_lat !== 2 || rd_id !== 1'b1) begin
      errors++;
      $display("FAIL incr_latency: got lat %0d rid %0d want 2 1", rd_lat, rd_id);
    end
    check_read("incr_read", 3, exp, RESP_OKAY);
  endtask

  task automatic test_strobe;
    logic [127:0] exp [256];
    wr_data[0] = {128{1'b1}}; wr_strb[0] = 16'hFFFF;
    axi_write(64'h0, 1'b0, 0, BURST_INCR, 3'd4);
    wr_data[0] = '0; wr_strb[0] = 16'h000F;
    axi_write(64'h0, 1'b0, 0, BURST_INCR, 3'd4);
    exp[0] = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_0000_0000;
    axi_read(64'h0, 1'b0, 0, BURST_INCR, 3'd4, 1'b0);
    check_read("strobe_read", 0, exp, RESP_OKAY);
  endtask

  task automatic test_stall;
    logic [127:0] exp [256];
    for (int i = 0; i < 8; i++) begin
      wr_data[i] = 128'h5A00 + 128'(i); wr_strb[i] = 16'hFFFF; exp[i] = 128'h5A00 + 128'(i);
    end
    axi_write(64'h400, 1'b0, 7, BURST_INCR, 3'd4);
    axi_read(64'h400, 1'b0, 7, BURST_INCR, 3'd4, 1'b1);
    checks++;
    if (rd_beats !== 8 || s_axi_RVALID !== 1'b0) begin
      errors++;
      $display("FAIL stall_count: got beats %0d rvalid %b want 8 0", rd_beats, s_axi_RVALID);
    end
    check_read("stall_read", 7, exp, RESP_OKAY);
  endtask

  task automatic test_errors;
    logic [127:0] exp [256];
    wr_data[0] = 128'hDEAD; wr_data[1] = 128'hBEEF; wr_strb[0] = 16'hFFFF; wr_strb[1] = 16'hFFFF;
    axi_write(64'h100, 1'b0, 1, BURST_WRAP, 3'd4);
    checks++;
    if (got_bresp !== RESP_SLVERR || wbeats !== 2) begin
      errors++;
      $display("FAIL wrap_write: got resp %0d beats %0d want 2 2", got_bresp, wbeats);
    end
    exp[0] = 128'd0; exp[1] = 128'd1;
    axi_read(64'h100, 1'b0, 1, BURST_INCR, 3'd4, 1'b0);
    check_read("wrap_unchanged", 1, exp, RESP_OKAY);

    wr_data[0] = 128'h1234;
    axi_write(64'h4000, 1'b1, 0, BURST_INCR, 3'd4);
    checks++;
    if (got_bresp !== RESP_SLVERR || got_bid !== 1'b1) begin
      errors++;
      $display("FAIL oor_write: got resp %0d id %0d want 2 1", got_bresp, got_bid);
    end
    exp[0] = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_0000_0000;
    axi_read(64'h0, 1'b0, 0, BURST_INCR, 3'd4, 1'b0);
    check_read("oor_no_alias", 0, exp, RESP_OKAY);

    exp[0] = '0;
    axi_read(64'h100, 1'b0, 0, BURST_INCR, 3'd2, 1'b0);
    check_read("bad_size_read", 0, exp, RESP_SLVERR);
  endtask

  task automatic test_wlast;
    logic [127:0] exp [256];
    for (int i = 0; i < 4; i++) begin
      wr_data[i] = 128'h10 + 128'(i); wr_strb[i] = 16'hFFFF; exp[i] = 128'h10 + 128'(i);
    end
    wlast_at = 1;
    axi_write(64'h300, 1'b0, 3, BURST_INCR, 3'd4);
    checks++;
    if (got_bresp !== RESP_SLVERR || wbeats !== 4) begin
      errors++;
      $display("FAIL wlast_write: got resp %0d beats %0d want 2 4", got_bresp, wbeats);
    end
    axi_read(64'h300, 1'b0, 3, BURST_INCR, 3'd4, 1'b0);
    check_read("wlast_read", 3, exp, RESP_OKAY);
  endtask

  task automatic test_fixed;
    logic [127:0] exp [256];
    for (int i = 0; i < 3; i++) begin wr_data[i] = 128'd5 + 128'(i); wr_strb[i] = 16'hFFFF; end
    axi_write(64'h500, 1'b0, 2, BURST_FIXED, 3'd4);
    checks++;
    if (got_bresp !== RESP_OKAY) begin
      errors++;
      $display("FAIL fixed_write: got resp %0d want 0", got_bresp);
    end
    exp[0] = 128'd7; exp[1] = 128'd7;
    axi_read(64'h500, 1'b0, 1, BURST_FIXED, 3'd4, 1'b0);
    check_read("fixed_read", 1, exp, RESP_OKAY);
  endtask

  task automatic test_concurrent;
    logic [127:0] exp [256];
    wr_data[0] = 128'h1111; wr_strb[0] = 16'hFFFF;
    axi_write(64'h200, 1'b0, 0, BURST_INCR, 3'd4);
    s_axi_AWVALID = 1'b1; s_axi_AWADDR = 64'h200; s_axi_AWID = 1'b0; s_axi_AWLEN = 8'd0;
    s_axi_AWSIZE = 3'd4; s_axi_AWBURST = BURST_INCR;
    s_axi_ARVALID = 1'b1; s_axi_ARADDR = 64'h200; s_axi_ARID = 1'b1; s_axi_ARLEN = 8'd0;
    s_axi_ARSIZE = 3'd4; s_axi_ARBURST = BURST_INCR;
    checks++;
    if (s_axi_AWREADY !== 1'b1 || s_axi_ARREADY !== 1'b1) begin
      errors++;
      $display("FAIL conc_ready: got aw %b ar %b want 1 1", s_axi_AWREADY, s_axi_ARREADY);
    end
    tick;
    s_axi_AWVALID = 1'b0; s_axi_ARVALID = 1'b0;
    s_axi_WVALID = 1'b1; s_axi_WDATA = 128'h2222; s_axi_WSTRB = 16'hFFFF; s_axi_WLAST = 1'b1;
    s_axi_RREADY = 1'b1;
    tick;
    s_axi_WVALID = 1'b0; s_axi_WLAST = 1'b0; s_axi_BREADY = 1'b1;
    checks++;
    if (s_axi_RVALID !== 1'b1 || s_axi_RDATA !== 128'h1111 || s_axi_BVALID !== 1'b1 ||
        s_axi_BRESP !== RESP_OKAY) begin
      errors++;
      $display("FAIL conc_read_first: got rvalid %b rdata %h bvalid %b want 1 1111 1",
               s_axi_RVALID, s_axi_RDATA, s_axi_BVALID);
    end
    tick;
    s_axi_RREADY = 1'b0; s_axi_BREADY = 1'b0;
    exp[0] = 128'h2222;
    axi_read(64'h200, 1'b0, 0, BURST_INCR, 3'd4, 1'b0);
    check_read("conc_new_data", 0, exp, RESP_OKAY);
  endtask

  task automatic test_reset_mid;
    logic [127:0] exp [256];
    int n;
    s_axi_ARVALID = 1'b1; s_axi_ARADDR = 64'h400; s_axi_ARID = 1'b0; s_axi_ARLEN = 8'd7;
    s_axi_ARSIZE = 3'd4; s_axi_ARBURST = BURST_INCR;
    tick;
    s_axi_ARVALID = 1'b0; s_axi_RREADY = 1'b1;
    n = 0;
    while (!s_axi_RVALID && n < 100) begin tick; n++; end
    if (!s_axi_RVALID) timeout("mid_rvalid");
    tick; tick;
    rst = 1'b1;
    tick;
    checks++;
    if (s_axi_RVALID !== 1'b0 || s_axi_ARREADY !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got rvalid %b arready %b want 0 0", s_axi_RVALID, s_axi_ARREADY);
    end
    s_axi_RREADY = 1'b0;
    tick;
    rst = 1'b0;
    #1;
    checks++;
    if (s_axi_ARREADY !== 1'b1 || s_axi_RVALID !== 1'b0) begin
      errors++;
      $display("FAIL mid_release: got arready %b rvalid %b want 1 0", s_axi_ARREADY, s_axi_RVALID);
    end
    for (int i = 0; i < 4; i++) exp[i] = 128'(i);
    axi_read(64'h100, 1'b0, 3, BURST_INCR, 3'd4, 1'b0);
    check_read("after_reset_read", 3, exp, RESP_OKAY);
  endtask

  initial begin
    rst = 1'b1; wlast_at = -1;
    s_axi_AWVALID = 1'b0; s_axi_AWADDR = '0; s_axi_AWID = '0; s_axi_AWLEN = '0;
    s_axi_AWSIZE = '0; s_axi_AWBURST = '0; s_axi_WVALID = 1'b0; s_axi_WDATA = '0;
    s_axi_WSTRB = '0; s_axi_WLAST = 1'b0; s_axi_BREADY = 1'b0; s_axi_ARVALID = 1'b0;
    s_axi_ARADDR = '0; s_axi_ARID = '0; s_axi_ARLEN = '0; s_axi_ARSIZE = '0;
    s_axi_ARBURST = '0; s_axi_RREADY = 1'b0;
    test_reset;
    test_incr;
    test_strobe;
    test_stall;
    test_errors;
    test_wlast;
    test_fixed;
    test_concurrent;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_mm_ram_slave.md
Name: axi_mm_ram_slave

Overview:
AXI4 full-protocol memory responder that terminates the 128-bit video master port (m_axi_mm_video0) of the HLS core for simulation and on-chip scratch use.
- Accepts independent read and write bursts, one outstanding per direction.
- Stores data in an internal byte-enabled RAM.
- Returns OKAY/SLVERR responses with the request ID echoed.
- Sits opposite the core's master port inside the test top.

Parameters:
ID_WIDTH, 1, AXI ID width.
ADDR_WIDTH, 64, AXI address width.
DATA_WIDTH, 128, data bus width; power of two, at least 32.
MEM_WORDS_LOG2, 10, log2 of RAM depth in DATA_WIDTH words (default 16 KiB).

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
s_axi_AWVALID/AWREADY  in/out  1  write address handshake
s_axi_AWADDR  in  ADDR_WIDTH  write start byte address
s_axi_AWID  in  ID_WIDTH  write ID
s_axi_AWLEN  in  8  beats minus 1
s_axi_AWSIZE  in  3  beat size
s_axi_AWBURST  in  2  burst type
s_axi_WVALID/WREADY  in/out  1  write data handshake
s_axi_WDATA  in  DATA_WIDTH  write data
s_axi_WSTRB  in  DATA_WIDTH/8  byte enables
s_axi_WLAST  in  1  last write beat
s_axi_BVALID/BREADY  out/in  1  write response handshake
s_axi_BRESP  out  2  write response
s_axi_BID  out  ID_WIDTH  echoed AWID
s_axi_ARVALID/ARREADY  in/out  1  read address handshake
s_axi_ARADDR  in  ADDR_WIDTH  read start byte address
s_axi_ARID  in  ID_WIDTH  read ID
s_axi_ARLEN  in  8  beats minus 1
s_axi_ARSIZE  in  3  beat size
s_axi_ARBURST  in  2  burst type
s_axi_RVALID/RREADY  out/in  1  read data handshake
s_axi_RDATA  out  DATA_WIDTH  read data
s_axi_RLAST  out  1  last read beat
s_axi_RID  out  ID_WIDTH  echoed ARID
s_axi_RRESP  out  2  read response

Behaviour:
- Reset (rst high): every valid/ready output is 0; BRESP, RRESP, RDATA, RLAST, BID, RID are 0.
- After reset: both FSMs go to IDLE, and AWREADY/ARREADY are 1 from the first cycle rst is low.
- RAM contents are not cleared. A reset mid-burst abandons the burst with no response issued.
- Word index is addr[B+MEM_WORDS_LOG2-1:B], where B = log2(DATA_WIDTH/8). Low B address bits are ignored.
- A beat is in range if addr >> B < 2^MEM_WORDS_LOG2.
- Burst legality:
  - Legal: BURST INCR (address += DATA_WIDTH/8 per beat) or FIXED (address constant).
  - Illegal: BURST WRAP or reserved, or SIZE != B. Such a burst still completes its full handshake, performs no RAM writes, returns zero read data, and responds SLVERR.
- Write FSM:
  - IDLE (AWREADY=1): on AW handshake, latch addr/ID/len/burst/legal, then go to DATA.
  - DATA (WREADY=1): each W handshake writes WDATA under WSTRB if the beat is legal and in range, then advances the address and beat count. The beat where count == AWLEN goes to RESP.
  - RESP (BVALID=1, BID=latched ID): on BREADY, return to IDLE.
  - BRESP=SLVERR if the burst is illegal, any beat is out of range, or WLAST != (count == AWLEN) on any beat. Otherwise OKAY.
  - Burst length is always AWLEN+1 beats; WLAST never shortens or extends it.
- Read FSM:
  - IDLE (ARREADY=1): on AR handshake, latch fields and go to FETCH.
  - FETCH: one cycle of RAM read, then go to DATA.
  - DATA (RVALID=1, RID=latched ID): RLAST=1 on beat ARLEN. The RAM read address is the next beat's address when RVALID&RREADY, else the current one. This sustains 1 beat/cycle under continuous RREADY, and RDATA is held stable while stalled. After the last handshake, return to IDLE.
  - Latency: AR handshake at cycle N gives first RVALID at N+2.
  - RRESP is per beat: SLVERR with zero data for illegal bursts or out-of-range beats, otherwise OKAY.
- Read and write channels run concurrently. A same-word write and read in the same cycle returns the old data (read-first).
- FIXED bursts of length 1..256 are allowed. INCR address wrap past the RAM top yields out-of-range beats, not modulo wrap.

Decomposition:
- Package axi_mm_ram_pkg: RESP_OKAY=2'b00, RESP_SLVERR=2'b10, BURST_FIXED=2'b00, BURST_INCR=2'b01, BURST_WRAP=2'b10, write and read FSM state enums.
- Sub-module axi_mm_ram_array: simple dual-port RAM with a byte-enabled write port and a registered read-first read port, both on clk.

Test Plan:
- Write INCR AWADDR=0x100, AWLEN=3, SIZE=4, data 0..3, WSTRB all 1s -> BRESP=OKAY, BID=AWID. Read back ARLEN=3 -> 0,1,2,3, RLAST on beat 3, first RVALID 2 cycles after AR.
- Write WSTRB=0x000F over pre-filled word 0xFF..FF at 0x0 with data 0 -> read returns low 4 bytes 0, rest 0xFF.
- RREADY toggled 1-0-1 during an 8-beat read -> RDATA stable while stalled, all 8 beats in order, no beat lost or repeated.
- AWBURST=WRAP, AWLEN=1 -> 2 beats accepted, memory unchanged, BRESP=SLVERR. AWADDR=0x4000 (out of range) -> SLVERR. ARSIZE=2 -> RRESP=SLVERR, RDATA=0.
- WLAST asserted on beat 1 of AWLEN=3 -> 4 beats still accepted and written, BRESP=SLVERR.
- Concurrent write and read to 0x200: read returns old data. rst asserted mid-read-burst -> RVALID=0 next cycle, ARREADY=1 after release, new burst served correctly.
